// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: follows the lamp phase sequence and countdown display, latching the first fault seen.
// Optional completed-cycle counter is built only when TRAFFIC_LIGHT_MONITOR_CYCLE_COUNT_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_SYNC   | waiting for the first one-hot lamp pattern to pick a phase
// ST_RED    | tracking red countdown
// ST_GREEN  | tracking green countdown
// ST_YELLOW | tracking yellow countdown
// ST_FAULT  | sticky fault; only i_clear or i_reset leave
module traffic_light_monitor #(
    parameter int RED_TICKS      = 10,
    parameter int GREEN_TICKS    = 7,
    parameter int YELLOW_TICKS   = 3,
    parameter int TIMEOUT_MARGIN = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic [2:0] i_led,
    input  logic [6:0] i_value,
    input  logic       i_clear,
    output logic [1:0] o_state,
    output logic       o_fault,
    output logic [2:0] o_fault_code,
    output logic [7:0] o_cycle_count
);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_RED,
        ST_GREEN,
        ST_YELLOW,
        ST_FAULT
    } state_t;

    localparam logic [6:0] RED_LOAD     = 7'(RED_TICKS);
    localparam logic [6:0] GREEN_LOAD   = 7'(GREEN_TICKS);
    localparam logic [6:0] YELLOW_LOAD  = 7'(YELLOW_TICKS);
    localparam logic [7:0] RED_LIMIT    = 8'(RED_TICKS + TIMEOUT_MARGIN);
    localparam logic [7:0] GREEN_LIMIT  = 8'(GREEN_TICKS + TIMEOUT_MARGIN);
    localparam logic [7:0] YELLOW_LIMIT = 8'(YELLOW_TICKS + TIMEOUT_MARGIN);

    state_t     state_q, state_d;
    logic [2:0] prev_led_q;
    logic [6:0] prev_value_q;
    logic [6:0] tick_cnt_q, tick_cnt_d;
    logic       loaded_q, loaded_d;
    logic [2:0] code_q, code_d;

    logic       led_one_hot;
    state_t     led_state;
    state_t     legal_next;
    logic [6:0] phase_load;
    logic [7:0] phase_limit;
    logic       in_phase;
    logic       phase_change;
    logic       step_ok;
    logic       f_lamp, f_order, f_step, f_timeout, f_early;
    logic       fault_any;
    logic [2:0] fault_code;

    always_comb begin
        led_one_hot = 1'b0;
        led_state   = ST_SYNC;
        case (i_led)
            3'b001: begin led_one_hot = 1'b1; led_state = ST_RED;    end
            3'b010: begin led_one_hot = 1'b1; led_state = ST_YELLOW; end
            3'b100: begin led_one_hot = 1'b1; led_state = ST_GREEN;  end
            default: ;
        endcase
    end

    always_comb begin
        in_phase    = 1'b1;
        legal_next  = ST_SYNC;
        phase_load  = '0;
        phase_limit = '0;
        case (state_q)
            ST_RED: begin
                legal_next  = ST_GREEN;
                phase_load  = RED_LOAD;
                phase_limit = RED_LIMIT;
            end
            ST_GREEN: begin
                legal_next  = ST_YELLOW;
                phase_load  = GREEN_LOAD;
                phase_limit = GREEN_LIMIT;
            end
            ST_YELLOW: begin
                legal_next  = ST_RED;
                phase_load  = YELLOW_LOAD;
                phase_limit = YELLOW_LIMIT;
            end
            default: in_phase = 1'b0;
        endcase
    end

    // A countdown may hold, step down by one, or reload from zero once per phase.
    always_comb begin
        phase_change = led_one_hot && (i_led != prev_led_q);
        step_ok = (i_value == prev_value_q)
               || ((prev_value_q != 7'd0) && (i_value == prev_value_q - 7'd1))
               || ((prev_value_q == 7'd0) && (i_value == phase_load) && !loaded_q);

        f_lamp    = in_phase && !led_one_hot;
        f_order   = in_phase && phase_change && (led_state != legal_next);
        f_step    = in_phase && led_one_hot && !phase_change && !step_ok;
        f_timeout = in_phase && i_tick && ({1'b0, tick_cnt_q} >= phase_limit);
        f_early   = in_phase && phase_change && !f_order && (prev_value_q != 7'd0);

        fault_any  = f_lamp || f_order || f_step || f_timeout || f_early;
        fault_code = 3'd0;
        if (f_lamp)         fault_code = 3'd1;
        else if (f_order)   fault_code = 3'd2;
        else if (f_step)    fault_code = 3'd3;
        else if (f_timeout) fault_code = 3'd4;
        else if (f_early)   fault_code = 3'd5;
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        loaded_d   = loaded_q;
        code_d     = code_q;
        case (state_q)
            ST_SYNC: begin
                if (led_one_hot) begin
                    state_d    = led_state;
                    tick_cnt_d = '0;
                    loaded_d   = (i_value != 7'd0);
                end
            end
            ST_FAULT: begin
                if (i_clear) begin
                    state_d = ST_SYNC;
                    code_d  = '0;
                end
            end
            default: begin
                if (fault_any) begin
                    state_d    = ST_FAULT;
                    code_d     = fault_code;
                    tick_cnt_d = '0;
                end else if (phase_change) begin
                    state_d    = led_state;
                    tick_cnt_d = '0;
                    loaded_d   = (i_value != 7'd0);
                end else begin
                    if (i_tick && (tick_cnt_q != 7'h7F))
                        tick_cnt_d = tick_cnt_q + 7'd1;
                    if ((prev_value_q == 7'd0) && (i_value != 7'd0))
                        loaded_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_SYNC;
            prev_led_q   <= '0;
            prev_value_q <= '0;
            tick_cnt_q   <= '0;
            loaded_q     <= 1'b0;
            code_q       <= '0;
        end else begin
            state_q      <= state_d;
            prev_led_q   <= i_led;
            prev_value_q <= i_value;
            tick_cnt_q   <= tick_cnt_d;
            loaded_q     <= loaded_d;
            code_q       <= code_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_RED:    o_state = 2'd1;
            ST_YELLOW: o_state = 2'd2;
            ST_GREEN:  o_state = 2'd3;
            default:   o_state = 2'd0;
        endcase
    end

    assign o_fault      = (state_q == ST_FAULT);
    assign o_fault_code = code_q;

`ifdef TRAFFIC_LIGHT_MONITOR_CYCLE_COUNT_EN
    // run_q: 0 none, 1 red seen, 2 red->green, 3 red->green->yellow since SYNC exit
    logic [1:0] run_q, run_d;
    logic [7:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        run_d       = run_q;
        cycle_cnt_d = cycle_cnt_q;
        case (state_q)
            ST_SYNC: run_d = (led_one_hot && (led_state == ST_RED)) ? 2'd1 : 2'd0;
            ST_FAULT: begin
                run_d = 2'd0;
                if (i_clear)
                    cycle_cnt_d = '0;
            end
            default: begin
                if (!fault_any && phase_change) begin
                    case (led_state)
                        ST_GREEN:  run_d = (run_q == 2'd1) ? 2'd2 : 2'd0;
                        ST_YELLOW: run_d = (run_q == 2'd2) ? 2'd3 : 2'd0;
                        ST_RED: begin
                            if ((run_q == 2'd3) && (cycle_cnt_q != 8'hFF))
                                cycle_cnt_d = cycle_cnt_q + 8'd1;
                            run_d = 2'd1;
                        end
                        default: run_d = 2'd0;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            run_q       <= 2'd0;
            cycle_cnt_q <= '0;
        end else begin
            run_q       <= run_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign o_cycle_count = cycle_cnt_q;
`else
    assign o_cycle_count = 8'd0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed testbench for traffic_light_monitor; expected cycle counts follow TRAFFIC_LIGHT_MONITOR_CYCLE_COUNT_EN.
module tb_traffic_light_monitor;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_tick = 1'b0;
    logic [2:0] i_led = 3'b000;
    logic [6:0] i_value = 7'd0;
    logic       i_clear = 1'b0;
    logic [1:0] o_state;
    logic       o_fault;
    logic [2:0] o_fault_code;
    logic [7:0] o_cycle_count;

    int vectors = 0;
    int errors  = 0;

    localparam logic [2:0] L_RED = 3'b001;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b100;
`ifdef TRAFFIC_LIGHT_MONITOR_CYCLE_COUNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    always #5 i_clk = ~i_clk;

    traffic_light_monitor dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_tick        (i_tick),
        .i_led         (i_led),
        .i_value       (i_value),
        .i_clear       (i_clear),
        .o_state       (o_state),
        .o_fault       (o_fault),
        .o_fault_code  (o_fault_code),
        .o_cycle_count (o_cycle_count)
    );

    // Apply one cycle of inputs, then settle just after the sampling edge.
    task automatic step(input logic [2:0] led, input logic [6:0] val, input logic tick, input logic clr);
        i_led   = led;
        i_value = val;
        i_tick  = tick;
        i_clear = clr;
        @(posedge i_clk);
        #1;
        i_tick  = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        step(3'b000, 7'd0, 1'b0, 1'b0);
        step(L_RED, 7'd5, 1'b1, 1'b1);
        vectors++;
        if ({o_fault, o_fault_code, o_state, o_cycle_count} !== 14'd0) begin
            errors++;
            $display("FAIL reset got fault=%0b code=%0d state=%0d cnt=%0d want all 0", o_fault, o_fault_code, o_state, o_cycle_count);
        end
        i_reset = 1'b0;
        step(3'b111, 7'd0, 1'b0, 1'b0);
        step(3'b011, 7'd9, 1'b0, 1'b0);
        vectors++;
        if ({o_fault, o_fault_code, o_state} !== 6'd0) begin
            errors++;
            $display("FAIL sync_ignore got fault=%0b code=%0d state=%0d want 0/0/0", o_fault, o_fault_code, o_state);
        end
    endtask

    task automatic test_nominal(input int n_cycles);
        step(L_RED, 7'd10, 1'b0, 1'b0);
        vectors++;
        if ({o_fault, o_state} !== {1'b0, 2'd1}) begin
            errors++;
            $display("FAIL nom_red_entry got fault=%0b state=%0d want 0/1", o_fault, o_state);
        end
        for (int v = 9; v >= 0; v--) begin
            step(L_RED, 7'(v), 1'b1, 1'b0);
            vectors++;
            if ({o_fault, o_state} !== {1'b0, 2'd1}) begin
                errors++;
                $display("FAIL nom_red v=%0d got fault=%0b state=%0d want 0/1", v, o_fault, o_state);
            end
        end
        step(L_GRN, 7'd0, 1'b0, 1'b0);
        vectors++;
        if ({o_fault, o_state} !== {1'b0, 2'd3}) begin
            errors++;
            $display("FAIL nom_green_entry got fault=%0b state=%0d want 0/3", o_fault, o_state);
        end
        step(L_GRN, 7'd7, 1'b0, 1'b0);
        for (int v = 6; v >= 0; v--) begin
            step(L_GRN, 7'(v), 1'b1, 1'b0);
            vectors++;
            if ({o_fault, o_state} !== {1'b0, 2'd3}) begin
                errors++;
                $display("FAIL nom_green v=%0d got fault=%0b state=%0d want 0/3", v, o_fault, o_state);
            end
        end
        step(L_YEL, 7'd3, 1'b0, 1'b0);
        for (int v = 2; v >= 0; v--) begin
            step(L_YEL, 7'(v), 1'b1, 1'b0);
            vectors++;
            if ({o_fault, o_state} !== {1'b0, 2'd2}) begin
                errors++;
                $display("FAIL nom_yellow v=%0d got fault=%0b state=%0d want 0/2", v, o_fault, o_state);
            end
        end
        step(L_RED, 7'd10, 1'b0, 1'b0);
        vectors++;
        if ({o_fault, o_state, o_cycle_count} !== {1'b0, 2'd1, 8'(n_cycles * CNT_EN)}) begin
            errors++;
            $display("FAIL nom_cycle got fault=%0b state=%0d cnt=%0d want 0/1/%0d", o_fault, o_state, o_cycle_count, n_cycles * CNT_EN);
        end
    endtask

    task automatic test_clear_outside_fault();
        step(L_RED, 7'd10, 1'b0, 1'b1);
        vectors++;
        if ({o_fault, o_state, o_cycle_count} !== {1'b0, 2'd1, 8'(2 * CNT_EN)}) begin
            errors++;
            $display("FAIL clear_no_effect got fault=%0b state=%0d cnt=%0d want 0/1/%0d", o_fault, o_state, o_cycle_count, 2 * CNT_EN);
        end
    endtask

    task automatic test_lamp_fault();
        for (int v = 9; v >= 0; v--) step(L_RED, 7'(v), 1'b0, 1'b0);
        step(L_GRN, 7'd7, 1'b0, 1'b0);
        step(L_GRN, 7'd6, 1'b0, 1'b0);
        step(L_GRN, 7'd5, 1'b0, 1'b0);
        step(3'b101, 7'd5, 1'b0, 1'b0);
        vectors++;
        if ({o_fault, o_fault_code, o_state} !== {1'b1, 3'd1, 2'd0}) begin
            errors++;
            $display("FAIL lamp_fault got fault=%0b code=%0d state=%0d want 1/1/0", o_fault, o_fault_code, o_state);
        end
        step(L_RED, 7'd10, 1'b1, 1'b0);
        step(L_YEL, 7'd0, 1'b0, 1'b0);
        vectors++;
        if ({o_fault, o_fault_code, o_state} !== {1'b1, 3'd1, 2'd0}) begin
            errors++;
            $display("FAIL fault_sticky got fault=%0b code=%0d state=%0d want 1/1/0", o_fault, o_fault_code, o_state);
        end
        step(L_RED, 7'd0, 1'b0, 1'b1);
        vectors++;
        if ({o_fault, o_fault_code, o_state, o_cycle_count} !== 14'd0) begin
            errors++;
            $display("FAIL lamp_clear got fault=%0b code=%0d state=%0d cnt=%0d want all 0", o_fault, o_fault_code, o_state, o_cycle_count);
        end
    endtask

    task automatic test_order_fault();
        step(L_RED, 7'd1, 1'b0, 1'b0);
        step(L_RED, 7'd0, 1'b0, 1'b0);
        step(L_YEL, 7'd0, 1'b0, 1'b0);
        vectors++;
        if ({o_fault, o_fault_code, o_state} !== {1'b1, 3'd2, 2'd0}) begin
            errors++;
            $display("FAIL order_fault got fault=%0b code=%0d state=%0d want 1/2/0", o_fault, o_fault_code, o_state);
        end
        step(L_YEL, 7'd0, 1'b0, 1'b1);
    endtask

    task automatic test_step_fault();
        step(L_GRN, 7'd5, 1'b0, 1'b0);
        vectors++;
        if ({o_fault, o_state} !== {1'b0, 2'd3}) begin
            errors++;
            $display("FAIL step_sync got fault=%0b state=%0d want 0/3", o_fault, o_state);
        end
        step(L_GRN, 7'd3, 1'b0, 1'b0);
        vectors++;
        if ({o_fault, o_fault_code, o_state} !== {1'b1, 3'd3, 2'd0}) begin
            errors++;
            $display("FAIL step_fault got fault=%0b code=%0d state=%0d want 1/3/0", o_fault, o_fault_code, o_state);
        end
        step(L_GRN, 7'd3, 1'b0, 1'b1);
        vectors++;
        if ({o_fault, o_fault_code, o_state} !== 6'd0) begin
            errors++;
            $display("FAIL step_clear got fault=%0b code=%0d state=%0d want 0/0/0", o_fault, o_fault_code, o_state);
        end
        step(3'b000, 7'd3, 1'b0, 1'b0);
        step(L_YEL, 7'd2, 1'b0, 1'b0);
        vectors++;
        if ({o_fault, o_state} !== {1'b0, 2'd2}) begin
            errors++;
            $display("FAIL resync_yellow got fault=%0b state=%0d want 0/2", o_fault, o_state);
        end
    endtask

    task automatic test_timeout_and_early();
        for (int t = 1; t <= 5; t++) begin
            step(L_YEL, 7'd2, 1'b1, 1'b0);
            vectors++;
            if ({o_fault, o_state} !== {1'b0, 2'd2}) begin
                errors++;
                $display("FAIL yellow_hold tick=%0d got fault=%0b state=%0d want 0/2", t, o_fault, o_state);
            end
        end
        step(L_YEL, 7'd2, 1'b1, 1'b0);
        vectors++;
        if ({o_fault, o_fault_code, o_state} !== {1'b1, 3'd4, 2'd0}) begin
            errors++;
            $display("FAIL yellow_timeout got fault=%0b code=%0d state=%0d want 1/4/0", o_fault, o_fault_code, o_state);
        end
        step(L_YEL, 7'd2, 1'b0, 1'b1);
        step(L_RED, 7'd4, 1'b0, 1'b0);
        step(L_GRN, 7'd4, 1'b0, 1'b0);
        vectors++;
        if ({o_fault, o_fault_code, o_state} !== {1'b1, 3'd5, 2'd0}) begin
            errors++;
            $display("FAIL early_switch got fault=%0b code=%0d state=%0d want 1/5/0", o_fault, o_fault_code, o_state);
        end
        step(L_GRN, 7'd4, 1'b0, 1'b1);
    endtask

    task automatic test_timeout_boundary();
        step(L_RED, 7'd10, 1'b0, 1'b0);
        for (int t = 1; t <= 12; t++) step(L_RED, 7'd10, 1'b1, 1'b0);
        vectors++;
        if ({o_fault, o_state} !== {1'b0, 2'd1}) begin
            errors++;
            $display("FAIL red_12_ticks got fault=%0b state=%0d want 0/1", o_fault, o_state);
        end
        step(L_RED, 7'd10, 1'b1, 1'b0);
        vectors++;
        if ({o_fault, o_fault_code} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL red_13_ticks got fault=%0b code=%0d want 1/4", o_fault, o_fault_code);
        end
        step(L_RED, 7'd10, 1'b0, 1'b1);
    endtask

    task automatic test_priority();
        step(L_RED, 7'd5, 1'b0, 1'b0);
        step(3'b000, 7'd1, 1'b1, 1'b0);
        vectors++;
        if (o_fault_code !== 3'd1) begin
            errors++;
            $display("FAIL prio_lamp_over_step got code=%0d want 1", o_fault_code);
        end
        step(3'b000, 7'd1, 1'b0, 1'b1);
        step(L_RED, 7'd5, 1'b0, 1'b0);
        step(L_YEL, 7'd5, 1'b0, 1'b0);
        vectors++;
        if (o_fault_code !== 3'd2) begin
            errors++;
            $display("FAIL prio_order_over_early got code=%0d want 2", o_fault_code);
        end
        step(L_YEL, 7'd5, 1'b0, 1'b1);
    endtask

    task automatic test_reset_priority();
        test_nominal(1);
        for (int v = 9; v >= 0; v--) step(L_RED, 7'(v), 1'b0, 1'b0);
        step(L_GRN, 7'd7, 1'b0, 1'b0);
        i_reset = 1'b1;
        step(L_GRN, 7'd6, 1'b1, 1'b1);
        i_reset = 1'b0;
        vectors++;
        if ({o_fault, o_fault_code, o_state, o_cycle_count} !== 14'd0) begin
            errors++;
            $display("FAIL reset_mid_green got fault=%0b code=%0d state=%0d cnt=%0d want all 0", o_fault, o_fault_code, o_state, o_cycle_count);
        end
        step(L_GRN, 7'd7, 1'b0, 1'b0);
        step(L_GRN, 7'd6, 1'b0, 1'b0);
        step(3'b110, 7'd6, 1'b0, 1'b0);
        vectors++;
        if ({o_fault, o_fault_code} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL pre_reset_fault got fault=%0b code=%0d want 1/1", o_fault, o_fault_code);
        end
        i_reset = 1'b1;
        step(L_GRN, 7'd6, 1'b1, 1'b1);
        i_reset = 1'b0;
        vectors++;
        if ({o_fault, o_fault_code, o_state, o_cycle_count} !== 14'd0) begin
            errors++;
            $display("FAIL reset_over_clear got fault=%0b code=%0d state=%0d cnt=%0d want all 0", o_fault, o_fault_code, o_state, o_cycle_count);
        end
        step(L_RED, 7'd10, 1'b0, 1'b0);
        i_reset = 1'b1;
        step(3'b111, 7'd3, 1'b1, 1'b0);
        i_reset = 1'b0;
        vectors++;
        if ({o_fault, o_fault_code, o_state} !== 6'd0) begin
            errors++;
            $display("FAIL reset_over_detect got fault=%0b code=%0d state=%0d want 0/0/0", o_fault, o_fault_code, o_state);
        end
    endtask

    initial begin
        test_reset();
        test_nominal(1);
        test_nominal(2);
        test_clear_outside_fault();
        test_lamp_fault();
        test_order_fault();
        test_step_fault();
        test_timeout_and_early();
        test_timeout_boundary();
        test_priority();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter RED_TICKS, default 10: legal red countdown load value.
REQ-002 Parameter GREEN_TICKS, default 7: legal green countdown load value.
REQ-003 Parameter YELLOW_TICKS, default 3: legal yellow countdown load value.
REQ-004 Parameter TIMEOUT_MARGIN, default 2: extra ticks tolerated per phase before timeout.
REQ-005 i_clk  input  1  single clock; all logic on rising edge.
REQ-006 i_reset  input  1  reset, synchronous, active-high.
REQ-007 i_tick  input  1  one-cycle 1 Hz tick strobe from the controller's tick generator.
REQ-008 i_led  input  3  observed lamp drive: bit0 red, bit1 yellow, bit2 green.
REQ-009 i_value  input  7  observed countdown display value.
REQ-010 i_clear  input  1  clears a latched fault; returns the monitor to SYNC.
REQ-011 o_state  output  2  tracked phase: 0 SYNC/FAULT, 1 RED, 2 YELLOW, 3 GREEN.
REQ-012 o_fault  output  1  sticky fault flag.
REQ-013 o_fault_code  output  3  code of first fault latched; 0 when no fault.
REQ-014 o_cycle_count  output  8  completed RED->GREEN->YELLOW->RED cycles (see Configuration).

Function
REQ-015 The FSM SHALL have states SYNC, RED, GREEN, YELLOW, FAULT; every input is sampled each cycle, with a registered copy of the previous i_led/i_value.
REQ-016 SYNC: on the first cycle i_led is one-hot, enter the matching phase; non-one-hot i_led in SYNC is ignored (no fault).
REQ-017 Legal phase order: RED->GREEN, GREEN->YELLOW, YELLOW->RED only; a phase change is detected when one-hot i_led differs from previous i_led.
REQ-018 Fault 1 (illegal lamp): in RED/GREEN/YELLOW, i_led not one-hot (zero or multiple bits).
REQ-019 Fault 2 (illegal order): one-hot i_led change that violates REQ-017.
REQ-020 Fault 5 (early switch): legal phase change while previous i_value != 0.
REQ-021 Fault 3 (bad step): within a phase, i_value change that is neither old-1 nor 0->phase load value (first load after entry only).
REQ-022 Fault 4 (timeout): per-phase tick counter, cleared on phase entry, incremented on i_tick; fault when it exceeds load value + TIMEOUT_MARGIN.
REQ-023 Any fault SHALL enter FAULT one cycle after detection, set o_fault=1, latch o_fault_code; simultaneous faults resolve lowest code first (1,2,3,4,5).
REQ-024 FAULT is sticky: ignores all inputs except i_clear and i_reset; o_state=0.
REQ-025 i_clear=1 in FAULT: next cycle o_fault=0, o_fault_code=0, state SYNC; i_clear outside FAULT has no effect.
REQ-026 Tick counter SHALL saturate at 7'h7F; no wrap.

Reset
REQ-027 i_reset=1 at a rising edge SHALL force SYNC, o_state=0, o_fault=0, o_fault_code=0, o_cycle_count=0, tick counter and history registers 0, regardless of state (including mid-phase or FAULT).
REQ-028 i_reset SHALL take priority over i_clear and all fault detection in the same cycle.

Configuration
REQ-029 Macro TRAFFIC_LIGHT_MONITOR_CYCLE_COUNT_EN defined: o_cycle_count increments by 1 on each YELLOW->RED transition preceded, since last SYNC exit, by an uninterrupted RED->GREEN->YELLOW run; saturates at 255; cleared by reset and i_clear.
REQ-030 Macro undefined: o_cycle_count SHALL be constant 0 and no counter logic synthesised; all other behaviour identical.

Verification
REQ-031 Reset, then nominal red 10..0, green 7..0, yellow 3..0, red with ticks -> o_fault=0 throughout, o_state 1->3->2->1, o_cycle_count=1 (macro on) / 0 (off).
REQ-032 In GREEN drive i_led=3'b101 one cycle -> o_fault=1, o_fault_code=1 next cycle, o_state=0.
REQ-033 In RED at i_value=0 switch i_led to 3'b010 -> o_fault_code=2.
REQ-034 In GREEN, i_value 5->3 -> o_fault_code=3; then i_clear=1 -> o_fault=0, o_state=0, re-sync on next one-hot i_led.
REQ-035 In YELLOW hold i_value=2 for 6 ticks (3+2+1) -> o_fault_code=4 on sixth tick +1 cycle; RED->GREEN at i_value=4 -> o_fault_code=5.
REQ-036 Assert i_reset mid-GREEN with o_fault=1 and i_clear=1 same cycle -> all outputs 0, state SYNC next cycle.
